// File: rtl/serial_divider_param.sv
// Bit-serial restoring divider: LSB-first operand load, WIDTH-cycle divide,
// LSB-first quotient/remainder stream with valid/ready backpressure.
module serial_divider_param #(
   parameter int WIDTH     = 16,
   parameter int SIGNED_EN = 1
) (
   input  logic clk,
   input  logic res,
   input  logic A,
   input  logic B,
   input  logic tvalid,
   output logic tready,
   input  logic mode_signed,
   output logic q_out,
   output logic r_out,
   output logic out_valid,
   input  logic out_ready,
   output logic out_last,
   output logic div_zero,
   output logic busy
);

   typedef enum logic [2:0] {
      LOAD,
      PREP,
      CALC,
      FIX,
      OUT
   } state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [WIDTH-1:0] dq;      // dividend magnitude in, quotient bits shift in behind it
   logic [WIDTH-1:0] dvs;     // divisor magnitude
   logic [WIDTH:0]   rem;     // partial remainder, one guard bit for the trial sign
   logic             sgn, sign_q, sign_r, dz;

   logic             in_beat, cnt_last, b_zero, s_a, s_b;
   logic [WIDTH:0]   shifted, trial;

   always_comb begin
      in_beat  = tvalid & tready;
      cnt_last = (cnt == CNT_LAST);
      b_zero   = (b_reg == '0);
      s_a      = sgn & a_reg[WIDTH-1];
      s_b      = sgn & b_reg[WIDTH-1];
      shifted  = {rem[WIDTH-1:0], dq[WIDTH-1]};
      trial    = shifted - {1'b0, dvs};
   end

   // NOTE: state register and datapath use <= only; all combinational
   // outputs get a default before the case so no latch can be inferred.
   always_ff @(posedge clk) begin
      if (!res) state <= LOAD;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tready    = 1'b0;
      out_valid = 1'b0;
      case (state)
         LOAD: begin
            tready = 1'b1;
            if (tvalid && cnt_last) state_nxt = PREP;
         end
         PREP:    state_nxt = b_zero ? FIX : CALC;
         CALC:    if (cnt_last) state_nxt = FIX;
         FIX:     state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready && cnt_last) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   assign out_last = (state == OUT) & cnt_last;
   assign q_out    = (state == OUT) & dq[0];
   assign r_out    = (state == OUT) & rem[0];
   assign div_zero = dz;
   assign busy     = !((state == LOAD) && (cnt == '0));

   always_ff @(posedge clk) begin
      if (!res) begin
         cnt    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         dq     <= '0;
         dvs    <= '0;
         rem    <= '0;
         sgn    <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         dz     <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (in_beat) begin
                  // shifting in from the top leaves beat k at bit k after WIDTH beats
                  a_reg <= {A, a_reg[WIDTH-1:1]};
                  b_reg <= {B, b_reg[WIDTH-1:1]};
                  if (cnt == '0) sgn <= mode_signed & (SIGNED_EN != 0);
                  cnt <= cnt_last ? '0 : cnt + CNT_ONE;
               end
            end
            PREP: begin
               dq     <= s_a ? -a_reg : a_reg;
               dvs    <= s_b ? -b_reg : b_reg;
               sign_q <= s_a ^ s_b;
               sign_r <= s_a;
               rem    <= '0;
               dz     <= b_zero;
               cnt    <= '0;
            end
            CALC: begin
               if (!trial[WIDTH]) begin
                  rem <= trial;
                  dq  <= {dq[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted;
                  dq  <= {dq[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt_last ? '0 : cnt + CNT_ONE;
            end
            FIX: begin
               if (dz) begin
                  dq  <= '1;
                  rem <= {1'b0, a_reg};
               end else begin
                  dq  <= sign_q ? -dq : dq;
                  rem <= {1'b0, sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]};
               end
               cnt <= '0;
            end
            OUT: begin
               if (out_ready) begin
                  dq  <= dq >> 1;
                  rem <= rem >> 1;
                  if (cnt_last) begin
                     cnt <= '0;
                     dz  <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule
